// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 16-way round-robin output arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/multiplexer_16_to_1.sv
// Plain 16-to-1 multiplexer of N-bit words.
module multiplexer_16_to_1 #(
  parameter int N = 8
) (
  input  logic [15:0][N-1:0] d,
  input  logic [3:0]         s,
  output logic [N-1:0]       y
);
  assign y = d[s];
endmodule

// File: rtl/rr_pick_16.sv
// Round-robin pick: first set request at or after ptr, wrapping past 15.
module rr_pick_16
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               ptr,
  output logic               found,
  output sel_t               idx
);
  logic [NUM_REQ-1:0] rot;
  sel_t               off;

  // rot[0] is the requester ptr points at, so the lowest set bit wins
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req[sel_t'(ptr + sel_t'(gi))];
  end

  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = sel_t'(k);
    end
  end

  assign idx   = ptr + off;
  assign found = |req;
endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin burst arbiter sharing one output channel among 16 requesters.
// Optional owner lock (suppresses burst-length rotation) under MUX_ARB_LOCK_EN.
module mux16_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0][N-1:0]   data_in,
  input  logic                        out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic                        lock,
`endif
  output logic                        out_valid,
  output logic [N-1:0]                out_data,
  output sel_t                        sel,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          ack
);
  localparam int               CNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t          state_reg;
  sel_t                sel_reg;
  sel_t                ptr_reg;
  logic [NUM_REQ-1:0]  grant_reg;
  logic [CNT_W-1:0]    beat_cnt_reg;

  logic                found;
  sel_t                pick_idx;
  logic                owner_req;
  logic                handshake;
  logic                lock_hold;
  logic                burst_done;
  logic [N-1:0]        mux_out;

  rr_pick_16 u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .found (found),
    .idx   (pick_idx)
  );

  multiplexer_16_to_1 #(.N(N)) u_mux (
    .d (data_in),
    .s (sel_reg),
    .y (mux_out)
  );

  assign owner_req = req[sel_reg];
  assign out_valid = (state_reg == BUSY) && owner_req;
  assign handshake = out_valid && out_ready;

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign burst_done = handshake && (beat_cnt_reg == CNT_LAST) && !lock_hold;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign ack[gi] = handshake && (sel_reg == sel_t'(gi));
  end

  assign out_data = out_valid ? mux_out : '0;
  assign sel      = sel_reg;
  assign grant    = grant_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            sel_reg             <= pick_idx;
            grant_reg           <= '0;
            grant_reg[pick_idx] <= 1'b1;
            beat_cnt_reg        <= '0;
            state_reg           <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req || burst_done) begin
            grant_reg <= '0;
            ptr_reg   <= sel_reg + 4'd1;
            state_reg <= IDLE;
          end else if (handshake && (beat_cnt_reg != CNT_LAST)) begin
            // counter holds at its last value while a lock keeps the burst open
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural owner/pointer model.
module tb_mux16_rr_arbiter;
  localparam int N  = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       req = '0;
  logic [15:0][N-1:0] data_in = '0;
  logic              out_ready = 1'b0;
  logic              lock_in = 1'b0;
  logic              out_valid;
  logic [N-1:0]      out_data;
  logic [3:0]        sel;
  logic [15:0]       grant;
  logic [15:0]       ack;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.N(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock_in),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .grant     (grant),
    .ack       (ack)
  );

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: who owns the channel, beats taken, where the search starts
  int m_owner = -1;
  int m_sel = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  logic [15:0] last_ack = '0;
  logic [15:0] prev_grant = '0;
  int ack_tally[16];
  int grant_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_sel = 0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    logic hs;
    logic lk;
`ifdef MUX_ARB_LOCK_EN
    lk = lock_in;
`else
    lk = 1'b0;
`endif
    if (m_owner < 0) begin
      for (int k = 0; k < 16; k++) begin
        int i;
        i = (m_ptr + k) % 16;
        if (req[i]) begin
          m_owner = i;
          m_sel = i;
          m_cnt = 0;
          break;
        end
      end
    end else begin
      hs = req[m_owner] && out_ready;
      if (!req[m_owner] || (hs && m_cnt == MB - 1 && !lk)) begin
        m_ptr = (m_owner + 1) % 16;
        m_owner = -1;
      end else if (hs && m_cnt < MB - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic clear_logs();
    foreach (ack_tally[i]) ack_tally[i] = 0;
    grant_log.delete();
  endtask

  // compare on the falling edge, advance the model on the rising edge, return 1ns later
  task automatic tick();
    logic [15:0]  eg;
    logic [15:0]  ea;
    logic         ev;
    logic [N-1:0] ed;
    @(negedge clk);
    eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
    ev = (m_owner >= 0) ? req[m_owner] : 1'b0;
    ed = ev ? data_in[m_owner] : '0;
    ea = (ev && out_ready) ? (16'd1 << m_owner) : 16'd0;
    chk("grant", 32'(grant), 32'(eg));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("ack", 32'(ack), 32'(ea));
    for (int i = 0; i < 16; i++) if (ack[i]) ack_tally[i]++;
    if (grant != 0 && prev_grant == 0) grant_log.push_back(int'(sel));
    prev_grant = grant;
    last_ack = ea;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    req = '0;
    out_ready = 1'b0;
    lock_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    prev_grant = '0;
  endtask

  initial begin
    // reset and single requester
    do_reset();
    data_in[3] = 8'hA5;
    req = 16'h0008;
    out_ready = 1'b1;
    tick();
    chk("t1_grant", 32'(grant), 32'h0008);
    chk("t1_sel", 32'(sel), 32'd3);
    chk("t1_data", 32'(out_data), 32'hA5);
    repeat (4) tick();
    chk("t1_acks", 32'(ack_tally[3]), 32'd4);
    chk("t1_release", 32'(grant), 32'h0);
    tick();
    chk("t1_regrant", 32'(grant), 32'h0008);

    // round-robin fairness with everyone requesting
    do_reset();
    for (int i = 0; i < 16; i++) data_in[i] = N'(8'h10 + i);
    req = 16'hFFFF;
    out_ready = 1'b1;
    repeat (17 * 5 + 2) tick();
    chk("fair_bursts", 32'(grant_log.size() >= 17), 32'd1);
    for (int k = 0; k < 17 && k < grant_log.size(); k++)
      chk("fair_order", 32'(grant_log[k]), 32'(k % 16));

    // wrap-around from 15 to 0
    do_reset();
    req = 16'h4000;
    out_ready = 1'b1;
    repeat (5) tick();
    req = 16'h8001;
    repeat (12) tick();
    chk("wrap_bursts", 32'(grant_log.size() >= 3), 32'd1);
    if (grant_log.size() >= 3) begin
      chk("wrap_first", 32'(grant_log[1]), 32'd15);
      chk("wrap_second", 32'(grant_log[2]), 32'd0);
    end

    // backpressure on owner 5
    do_reset();
    data_in[5] = 8'h3C;
    req = 16'h0020;
    out_ready = 1'b0;
    tick();
    repeat (10) begin
      tick();
      chk("bp_data", 32'(out_data), 32'h3C);
    end
    chk("bp_no_ack", 32'(ack_tally[5]), 32'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_acks", 32'(ack_tally[5]), 32'd4);
    chk("bp_release", 32'(grant), 32'h0);

    // withdrawal by owner 7 after two beats, next search starts at 8
    do_reset();
    req = 16'h0080;
    out_ready = 1'b1;
    repeat (3) tick();
    req = 16'h0140;
    tick();
    tick();
    chk("wd_acks", 32'(ack_tally[7]), 32'd2);
    chk("wd_grant", 32'(grant), 32'h0100);
    chk("wd_sel", 32'(sel), 32'd8);

    // asynchronous reset mid-burst
    do_reset();
    req = 16'h0080;
    out_ready = 1'b1;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_ack", 32'(ack), 32'h0);
    tick();

`ifdef MUX_ARB_LOCK_EN
    // locked owner keeps the channel past the burst limit
    do_reset();
    req = 16'h0004;
    out_ready = 1'b1;
    lock_in = 1'b1;
    tick();
    repeat (9) tick();
    chk("lock_acks", 32'(ack_tally[2]), 32'd9);
    chk("lock_grant", 32'(grant), 32'h0004);
    req = 16'h0;
    tick();
    chk("lock_release", 32'(grant), 32'h0);
    lock_in = 1'b0;
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 16; i++) data_in[i] = N'($urandom);
    repeat (3000) begin
      for (int i = 0; i < 16; i++) begin
        if (!req[i]) begin
          data_in[i] = N'($urandom);
          if ($urandom_range(0, 99) < 20) req[i] = 1'b1;
        end else if (last_ack[i]) begin
          data_in[i] = N'($urandom);
          if ($urandom_range(0, 99) < 30) req[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 3) begin
          req[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
`ifdef MUX_ARB_LOCK_EN
      lock_in = ($urandom_range(0, 99) < 25);
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares one N-bit output channel among 16 requesters.
- Registers a 4-bit select and drives it into a multiplexer_16_to_1 datapath.
- Grants are bursts of up to MAX_BURST beats, with valid/ready on the output side and a one-hot ack back to the owner.
- Sits between 16 producer blocks and a single downstream consumer.

Parameters:
- N, 8, data width per requester and of out_data.
- MAX_BURST, 4, maximum beats per grant before forced rotation. Legal range 1..256.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  16  per-requester request. Held high while that requester has a beat ready.
- data_in  input  16xN  packed array, data_in[i] is requester i's beat. Held stable while req[i]=1 and no ack[i].
- out_ready  input  1  downstream accepts the beat this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  N  data_in[sel] when out_valid, else 0.
- sel  output  4  registered index of the current owner.
- grant  output  16  registered one-hot of the owner; 0 when idle.
- ack  output  16  combinational one-hot pulse: ack[sel]=out_valid&out_ready.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; sel=0, grant=0, ptr=0, beat_cnt=0.
  - out_valid=0, out_data=0, ack=0.
  - Reset mid-burst drops the grant immediately. No ack is issued.
- IDLE:
  - If req!=0, pick the first i with req[i]=1 in the order ptr, ptr+1, …, 15, 0, …, ptr-1.
  - Next edge: sel=i, grant=1<<i, beat_cnt=0, state=BUSY.
  - Latency: req high at edge t gives grant at edge t+1.
- BUSY:
  - out_valid=req[sel], combinational.
  - Handshake = out_valid&out_ready. On a handshake, ack[sel]=1 in the same cycle and beat_cnt increments.
  - Release conditions, each taking effect at the next edge:
    - (a) handshake with beat_cnt==MAX_BURST-1;
    - (b) req[sel]=0 at a sampling edge, i.e. requester withdrew.
  - On release: grant=0, ptr=(sel+1) mod 16 (wraps 15→0), state=IDLE.
  - sel keeps its value while IDLE, but out_data is forced to 0.
- Re-arbitration after release costs exactly one idle cycle (the IDLE state). No back-to-back grants.
- out_ready high with out_valid low: no effect.
- Requester whose req rises while another requester owns the channel waits. Its request is not lost.
- Only one requester: it is re-granted after each release, with one bubble cycle between bursts.
- MAX_BURST=1: every accepted beat releases.
- beat_cnt width is $clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1.

Optional Feature:
- Macro name: MUX_ARB_LOCK_EN.
- Defined:
  - Adds input lock (1 bit). While in BUSY with lock=1, release condition (a) is suppressed.
  - beat_cnt saturates at MAX_BURST-1.
  - Condition (b) still releases.
  - Lock is sampled only from the current owner's cycle; lock in IDLE is ignored.
- Undefined: no lock port; behaviour as above.

Decomposition:
- Package mux_arb_pkg:
  - NUM_REQ=16, SEL_W=4;
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - typedef logic [SEL_W-1:0] sel_t.
- Sub-module rr_pick_16: combinational.
  - Inputs: req[16], ptr[4].
  - Outputs: found, idx[4].
  - Implemented as rotate, priority encode, un-rotate.
- Datapath: one multiplexer_16_to_1 #(N) instance, select driven by sel. Output gated by out_valid.

Test Plan:
- Reset and single requester:
  - Stimulus: reset, then req=16'h0008, data_in[3]=8'hA5, out_ready=1.
  - Response: grant=16'h0008 and sel=3 one edge later; out_data=8'hA5.
  - 4 acks, then release; ptr=4; one idle cycle; re-grant.
- Round-robin fairness:
  - Stimulus: req=16'hFFFF constant, out_ready=1, MAX_BURST=4.
  - Response: sel sequence 0,1,…,15,0. Each burst is 4 acks separated by one idle cycle.
- Wrap-around:
  - Stimulus: ptr=15 after serving req[14]; req=16'h8001.
  - Response: 15 granted next, then 0.
- Backpressure:
  - Stimulus: owner 5, out_ready=0 for 10 cycles.
  - Response: out_valid=1, out_data stable, ack=0, beat_cnt unchanged. Burst completes after out_ready returns.
- Withdrawal and async reset:
  - Stimulus: owner 7 drops req after 2 acks.
  - Response: release, ptr=8.
  - Stimulus: separately, rst_n=0 mid-burst.
  - Response: grant=0 and out_valid=0 immediately, without waiting for clk.
- MUX_ARB_LOCK_EN:
  - Stimulus: owner 2 with lock=1 for 9 beats, MAX_BURST=4.
  - Response: 9 acks without rotation. Release when req[2] drops.
